// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC iteration controller: FSM state
// encoding, default iteration count and index width.
// Optional feature macro: CORDIC_GAIN_COMP_EN (adds the COMP state).
package cordic_pkg;

    // Default number of micro-rotations and width of the iteration index
    localparam int CORDIC_ITERS = 12;
    localparam int CORDIC_IDX_W = 4;

    // IDLE, LOAD, ITER, COMP, DONE (COMP only used with gain compensation)
    localparam int CORDIC_NUM_STATES = 5;
    localparam int CORDIC_ST_W       = $clog2(CORDIC_NUM_STATES);

    typedef logic [CORDIC_ST_W-1:0] state_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_COMP = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Iteration index counter for the CORDIC controller. Synchronous clear
// has priority over enable; tc flags the last micro-rotation (ITERS-1).
module cordic_iter_cnt
    import cordic_pkg::*;
#(
    parameter int ITERS = CORDIC_ITERS,
    parameter int IDX_W = CORDIC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] cnt,
    output logic             tc
);

    logic [IDX_W-1:0] cnt_reg;

    // Count up while enabled; reset or clear returns the index to zero
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + IDX_W'(1);
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == IDX_W'(ITERS - 1));

endmodule

// File: rtl/cordic_ctrl.sv
// Control FSM for an iterative CORDIC datapath: load strobe, ITERS
// micro-rotation enables with a shift/ROM index, optional one-cycle gain
// compensation, then a held result-valid until the consumer acknowledges.
// Optional feature macro: CORDIC_GAIN_COMP_EN (COMP state + comp_en strobe).
// All outputs are pure decodes of registered state, so no input reaches an
// output combinationally.
module cordic_ctrl
    import cordic_pkg::*;
#(
    parameter int ITERS = CORDIC_ITERS,
    parameter int IDX_W = CORDIC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             out_ack,
    output logic             ready,
    output logic             ld,
    output logic             it_en,
    output logic [IDX_W-1:0] idx,
    output logic             comp_en,
    output logic             out_valid
);

    state_t           state_reg;
    state_t           state_next;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [IDX_W-1:0] cnt;

    // Next-state logic; abort dominates start, out_ack and the count
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (start) state_next = ST_LOAD;
                ST_LOAD: state_next = ST_ITER;
`ifdef CORDIC_GAIN_COMP_EN
                ST_ITER: if (cnt_tc) state_next = ST_COMP;
                ST_COMP: state_next = ST_DONE;
`else
                ST_ITER: if (cnt_tc) state_next = ST_DONE;
`endif
                ST_DONE: if (out_ack) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register; reset overrides every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The counter only runs in ITER and is cleared on the last rotation so
    // the index reads zero everywhere else and never passes ITERS-1.
    assign cnt_en  = (state_reg == ST_ITER);
    assign cnt_clr = (state_reg != ST_ITER) || cnt_tc || abort;

    cordic_iter_cnt #(
        .ITERS (ITERS),
        .IDX_W (IDX_W)
    ) u_iter_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    assign ready     = (state_reg == ST_IDLE);
    assign ld        = (state_reg == ST_LOAD);
    assign it_en     = (state_reg == ST_ITER);
    assign idx       = cnt;
    assign out_valid = (state_reg == ST_DONE);
`ifdef CORDIC_GAIN_COMP_EN
    assign comp_en   = (state_reg == ST_COMP);
`else
    assign comp_en   = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_ctrl.sv
// Scoreboard bench for cordic_ctrl: one instance with ITERS=12, one with
// ITERS=1. The stimulus process pushes expected results and expected
// output snapshots; a negedge monitor pops and compares them.
// Honours CORDIC_GAIN_COMP_EN for the expected latency and comp strobe.
module tb_cordic_ctrl;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int IT0  = 12;
    localparam int IT1  = 1;
    localparam int LAT0 = IT0 + 2 + EXTRA;
    localparam int LAT1 = IT1 + 2 + EXTRA;

    // Snapshot layout: {ready, ld, it_en, comp_en, out_valid, idx[3:0]}
    localparam logic [8:0] IDLE_VEC = 9'h100;
    localparam logic [8:0] LD_VEC   = 9'h080;
    localparam logic [8:0] IT0_VEC  = 9'h040;
    localparam logic [8:0] DONE_VEC = 9'h010;

    typedef struct {
        int dut;
        int done_cyc;
        int n_iter;
        int n_comp;
    } res_t;

    typedef struct {
        int         cyc;
        int         dut;
        string      name;
        logic [8:0] vec;
    } spot_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_a, abort_a, ack_a;
    logic [1:0] ready_a, ld_a, it_a, comp_a, ov_a;
    logic [3:0] idx_a [2];

    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    bit    done_flag = 1'b0;
    res_t  res_q[$];
    spot_t spot_q[$];

    int it_seen   [2] = '{0, 0};
    int ld_seen   [2] = '{0, 0};
    int comp_seen [2] = '{0, 0};
    bit ov_prev   [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cordic_ctrl #(.ITERS(IT0), .IDX_W(4)) dut0 (
        .clk(clk), .rst(rst), .start(start_a[0]), .abort(abort_a[0]),
        .out_ack(ack_a[0]), .ready(ready_a[0]), .ld(ld_a[0]), .it_en(it_a[0]),
        .idx(idx_a[0]), .comp_en(comp_a[0]), .out_valid(ov_a[0])
    );

    cordic_ctrl #(.ITERS(IT1), .IDX_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start_a[1]), .abort(abort_a[1]),
        .out_ack(ack_a[1]), .ready(ready_a[1]), .ld(ld_a[1]), .it_en(it_a[1]),
        .idx(idx_a[1]), .comp_en(comp_a[1]), .out_valid(ov_a[1])
    );

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] snap(input int d);
        return {ready_a[d], ld_a[d], it_a[d], comp_a[d], ov_a[d], idx_a[d]};
    endfunction

    always @(negedge clk) begin
        spot_t s;
        res_t  e;
        while (spot_q.size() > 0 && spot_q[0].cyc <= cyc) begin
            s = spot_q.pop_front();
            chk(s.name, int'(snap(s.dut)), int'(s.vec));
        end
        for (int d = 0; d < 2; d++) begin
            if (ready_a[d] === 1'b1) ld_seen[d] = 0;
            if (ld_a[d] === 1'b1) begin
                ld_seen[d]++;
                it_seen[d]   = 0;
                comp_seen[d] = 0;
            end
            if (it_a[d] === 1'b1) begin
                chk("idx_sequence", int'(idx_a[d]), it_seen[d]);
                it_seen[d]++;
            end
            if (comp_a[d] === 1'b1) comp_seen[d]++;
            if (ov_a[d] === 1'b1 && !ov_prev[d]) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = res_q.pop_front();
                    $display("result dut%0d at cycle %0d: %0d it_en, %0d comp_en", d, cyc,
                             it_seen[d], comp_seen[d]);
                    chk("result_dut", d, e.dut);
                    chk("result_latency", cyc, e.done_cyc);
                    chk("result_iters", it_seen[d], e.n_iter);
                    chk("result_comp", comp_seen[d], e.n_comp);
                    chk("result_loads", ld_seen[d], 1);
                end
                ld_seen[d] = 0;
            end
            ov_prev[d] = (ov_a[d] === 1'b1);
        end
        if (done_flag) begin
            chk("results_drained", res_q.size(), 0);
            chk("spots_drained", spot_q.size(), 0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int d, input string name, input logic [8:0] v);
        spot_t s;
        s.cyc = c; s.dut = d; s.name = name; s.vec = v;
        spot_q.push_back(s);
    endtask

    task automatic push_res(input int d, input int done_c, input int n_it);
        res_t e;
        e.dut = d; e.done_cyc = done_c; e.n_iter = n_it; e.n_comp = EXTRA;
        res_q.push_back(e);
    endtask

    task automatic wait_ov(input int d);
        for (int n = 0; n < 64; n++) begin
            if (ov_a[d] === 1'b1) return;
            step();
        end
        $display("FAIL wait_out_valid: dut%0d out_valid still low, expected high within 64 cycles", d);
        $fatal(1, "out_valid timeout");
    endtask

    task automatic wait_idx(input int d, input logic [3:0] v);
        for (int n = 0; n < 64; n++) begin
            if (it_a[d] === 1'b1 && idx_a[d] == v) return;
            step();
        end
        $display("FAIL wait_idx: dut%0d idx never reached %0d", d, v);
        $fatal(1, "idx timeout");
    endtask

    initial begin
        rst = 1'b1; start_a = '0; abort_a = '0; ack_a = '0;
        step(); step();
        expect_at(cyc, 0, "reset_dut0", IDLE_VEC);
        expect_at(cyc, 1, "reset_dut1", IDLE_VEC);
        rst = 1'b0;
        step();

        // Single operation: ld, 12 rotations, result, ack back to ready
        start_a[0] = 1'b1;
        push_res(0, cyc + LAT0, IT0);
        expect_at(cyc + 1, 0, "load_strobe", LD_VEC);
        expect_at(cyc + 2, 0, "first_iter", IT0_VEC);
        step(); start_a[0] = 1'b0;
        wait_ov(0);
        ack_a[0] = 1'b1;
        expect_at(cyc + 1, 0, "ack_to_ready", IDLE_VEC);
        step(); ack_a[0] = 1'b0;

        // start held through an operation: no queuing, restart only from IDLE
        start_a[0] = 1'b1;
        push_res(0, cyc + LAT0, IT0);
        step();
        wait_ov(0);
        ack_a[0] = 1'b1;
        step(); ack_a[0] = 1'b0;
        expect_at(cyc, 0, "held_start_idle", IDLE_VEC);
        push_res(0, cyc + LAT0, IT0);
        expect_at(cyc + 1, 0, "held_start_load", LD_VEC);
        step();
        wait_ov(0);
        start_a[0] = 1'b0; ack_a[0] = 1'b1;
        step(); ack_a[0] = 1'b0;
        expect_at(cyc, 0, "held_start_ack", IDLE_VEC);
        step();
        expect_at(cyc, 0, "no_extra_op", IDLE_VEC);
        step();

        // abort beats a coincident start
        start_a[0] = 1'b1; abort_a[0] = 1'b1;
        expect_at(cyc + 1, 0, "abort_over_start", IDLE_VEC);
        step(); start_a[0] = 1'b0; abort_a[0] = 1'b0;

        // abort mid-iteration at idx=5, then a fresh run from idx 0
        start_a[0] = 1'b1;
        step(); start_a[0] = 1'b0;
        wait_idx(0, 4'd5);
        abort_a[0] = 1'b1;
        expect_at(cyc + 1, 0, "abort_at_idx5", IDLE_VEC);
        step(); abort_a[0] = 1'b0;
        start_a[0] = 1'b1;
        push_res(0, cyc + LAT0, IT0);
        expect_at(cyc + 2, 0, "restart_idx0", IT0_VEC);
        step(); start_a[0] = 1'b0;
        wait_ov(0);

        // reset while DONE with out_ack high
        rst = 1'b1; ack_a[0] = 1'b1;
        expect_at(cyc + 1, 0, "rst_in_done", IDLE_VEC);
        step(); rst = 1'b0; ack_a[0] = 1'b0;
        step();

        // ITERS=1 instance: one rotation, out_valid held while unacknowledged
        start_a[1] = 1'b1;
        push_res(1, cyc + LAT1, IT1);
        expect_at(cyc + 1, 1, "iters1_load", LD_VEC);
        expect_at(cyc + 2, 1, "iters1_iter", IT0_VEC);
        step(); start_a[1] = 1'b0;
        wait_ov(1);
        for (int k = 0; k < 10; k++) begin
            expect_at(cyc, 1, "iters1_hold_valid", DONE_VEC);
            step();
        end
        ack_a[1] = 1'b1;
        expect_at(cyc + 1, 1, "iters1_ack", IDLE_VEC);
        step(); ack_a[1] = 1'b0;
        step(); step();
        done_flag = 1'b1;
    end

    // Absolute backstop so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/cordic_ctrl.md
CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 SHALL have parameter ITERS, default 12, number of CORDIC micro-rotations per operation; legal range 1..15.
REQ-002 SHALL have parameter IDX_W, default 4, width of the iteration index.
REQ-003 SHALL have clk  input  1  the one clock; all state updates on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have start  input  1  operation request; accepted only when ready=1.
REQ-006 SHALL have abort  input  1  synchronous cancel of any in-flight operation.
REQ-007 SHALL have out_ack  input  1  consumer acknowledge of a completed result.
REQ-008 SHALL have ready  output  1  high only in IDLE.
REQ-009 SHALL have ld  output  1  one-cycle load strobe for the datapath x/y/z registers.
REQ-010 SHALL have it_en  output  1  datapath micro-rotation enable.
REQ-011 SHALL have idx  output  IDX_W  shift amount and atan-ROM address for the current micro-rotation.
REQ-012 SHALL have comp_en  output  1  gain-compensation strobe (see Configuration).
REQ-013 SHALL have out_valid  output  1  result valid, held until acknowledged.

Function
REQ-014 SHALL implement the states IDLE, LOAD, ITER, COMP, DONE; COMP exists only per REQ-031.
REQ-015 SHALL move IDLE->LOAD on start=1; start in any other state SHALL be ignored, not queued.
REQ-016 SHALL assert ld=1 for exactly the single LOAD cycle, then enter ITER.
REQ-017 SHALL assert it_en=1 in each ITER cycle, with idx=0 in the first ITER cycle, incrementing by 1 per cycle.
REQ-018 SHALL leave ITER after the cycle where idx=ITERS-1, giving exactly ITERS it_en cycles.
REQ-019 SHALL hold idx at 0 in every state other than ITER; idx never wraps or exceeds ITERS-1.
REQ-020 SHALL assert out_valid=1 throughout DONE and SHALL move DONE->IDLE on the edge at which out_ack=1.
REQ-021 SHALL ignore out_ack outside DONE.
REQ-022 SHALL make out_valid first high ITERS+2 cycles after the accepting edge, or ITERS+3 with REQ-031.
REQ-023 SHALL, on abort=1, go to IDLE on the next edge from any state, with all strobes low from that edge on.
REQ-024 SHALL give abort priority over start, out_ack and the iteration count when they coincide.
REQ-025 SHALL accept start in the cycle immediately after the DONE->IDLE transition, with no dead cycle beyond IDLE.
REQ-026 SHALL drive all outputs as registered or pure state decodes, with no combinational input-to-output path except none.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, enter IDLE and clear the iteration counter, overriding abort and every other input.
REQ-028 SHALL produce these reset values: ready=1, ld=0, it_en=0, idx=0, comp_en=0, out_valid=0.
REQ-029 SHALL treat rst mid-operation identically to REQ-027, discarding the in-flight operation.

Configuration
REQ-030 SHALL be controlled by the macro CORDIC_GAIN_COMP_EN.
REQ-031 SHALL, with CORDIC_GAIN_COMP_EN defined, insert COMP for one cycle between the last ITER cycle and DONE, with comp_en=1 in that cycle.
REQ-032 SHALL, with CORDIC_GAIN_COMP_EN undefined, go ITER->DONE directly, tie comp_en to 0, and contain no COMP state logic.

Structure
REQ-033 SHALL take the state encoding typedef, the default ITERS and IDX_W constants, and the state count from shared package cordic_pkg.
REQ-034 SHALL instantiate one sub-module, cordic_iter_cnt: an IDX_W-bit counter with sync clear, enable and terminal-count output at ITERS-1.

Verification
REQ-035 SHALL cover: ITERS=12, start pulse in IDLE -> ld for 1 cycle, it_en for 12 cycles with idx 0..11, out_valid at cycle 14; out_ack -> ready next cycle.
REQ-036 SHALL cover: start held high throughout an operation -> exactly one operation; a second operation begins only after returning to IDLE.
REQ-037 SHALL cover: abort at idx=5 -> ready=1 and it_en=0 on the next edge; a fresh start -> idx restarts at 0.
REQ-038 SHALL cover: rst=1 in DONE with out_ack=1 -> all reset values per REQ-028 next cycle; no out_ack effect.
REQ-039 SHALL cover: CORDIC_GAIN_COMP_EN defined, ITERS=12 -> comp_en for 1 cycle after idx=11; out_valid at cycle 15.
REQ-040 SHALL cover: ITERS=1 and out_ack held low for 10 cycles in DONE -> one it_en cycle with idx=0; out_valid held all 10 cycles.
